// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - handshake and ALU bus bundle for alu_issue
//
// Purpose: groups the decode-side request, ALU drive/return and writeback
//          response signals of alu_issue into one bundle.
// Modports:
//   slave  - the issue block: takes in_*, result, out_ready; drives
//            in_ready, func, op_0, op_1, out_*.
//   master - the surrounding pipeline/ALU: the mirror image.

interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [5:0]  func;
  logic [31:0] op_0;
  logic [31:0] op_1;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_err;

  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, result, out_ready,
    output in_ready, func, op_0, op_1, out_valid, out_result, out_rd, out_err
  );

  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, result, out_ready,
    input  in_ready, func, op_0, op_1, out_valid, out_result, out_rd, out_err
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - MIPS R-type ALU issue stage with multi-cycle mult/div hold
//
// Purpose: accepts one instruction at a time, decodes it to an ALU func code
//          and operands, holds them on the ALU for 1 cycle (or MULDIV_CYCLES
//          for mult/multu/div/divu), captures the ALU result and offers it to
//          writeback until consumed.
// Parameter: MULDIV_CYCLES (1..15) - ALU hold time for mult/div operations.
// Optional feature: define ALU_IMM_EN to decode addi/addiu/andi/ori/xori.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_if.slave: in_* request, func/op_0/op_1/result ALU
//           drive, out_* writeback response

module alu_issue #(
  parameter int MULDIV_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [5:0]  r_func;
  logic [31:0] r_op_0;
  logic [31:0] r_op_1;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_err;
  logic        r_muldiv;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic        w_legal;
  logic        w_muldiv;
  logic [5:0]  w_func;
  logic [31:0] w_op_0;
  logic [31:0] w_op_1;
  logic [4:0]  w_rd;
  logic        w_accept;
  logic        w_capture;
  logic        w_unused_bits;

  assign w_opcode      = bus.in_instr[31:26];
  assign w_funct       = bus.in_instr[5:0];
  assign w_unused_bits = ^bus.in_instr[25:16];

  always_comb begin
    w_legal  = 1'b0;
    w_muldiv = 1'b0;
    w_func   = 6'h00;
    w_op_0   = bus.in_rs_val;
    w_op_1   = bus.in_rt_val;
    w_rd     = bus.in_instr[15:11];
    if (w_opcode == 6'h00) begin
      w_legal = 1'b1;
      case (w_funct)
        6'h20: w_func = 6'h00;
        6'h21: w_func = 6'h01;
        6'h22: w_func = 6'h02;
        6'h23: w_func = 6'h03;
        6'h18: begin w_func = 6'h04; w_muldiv = 1'b1; end
        6'h19: begin w_func = 6'h05; w_muldiv = 1'b1; end
        6'h1A: begin w_func = 6'h06; w_muldiv = 1'b1; end
        6'h1B: begin w_func = 6'h07; w_muldiv = 1'b1; end
        6'h24: w_func = 6'h08;
        6'h25: w_func = 6'h09;
        6'h26: w_func = 6'h10;
        6'h27: w_func = 6'h11;
        // Shifts: the shifted value is rt, the amount is the shamt field.
        6'h00: begin w_func = 6'h12; w_op_0 = bus.in_rt_val; w_op_1 = {27'd0, bus.in_instr[10:6]}; end
        6'h03: begin w_func = 6'h13; w_op_0 = bus.in_rt_val; w_op_1 = {27'd0, bus.in_instr[10:6]}; end
        6'h02: begin w_func = 6'h14; w_op_0 = bus.in_rt_val; w_op_1 = {27'd0, bus.in_instr[10:6]}; end
        default: w_legal = 1'b0;
      endcase
    end
`ifdef ALU_IMM_EN
    else begin
      w_legal = 1'b1;
      w_rd    = bus.in_instr[20:16];
      case (w_opcode)
        6'h08: begin w_func = 6'h00; w_op_1 = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]}; end
        6'h09: begin w_func = 6'h01; w_op_1 = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]}; end
        6'h0C: begin w_func = 6'h08; w_op_1 = {16'd0, bus.in_instr[15:0]}; end
        6'h0D: begin w_func = 6'h09; w_op_1 = {16'd0, bus.in_instr[15:0]}; end
        6'h0E: begin w_func = 6'h10; w_op_1 = {16'd0, bus.in_instr[15:0]}; end
        default: w_legal = 1'b0;
      endcase
    end
`endif
  end

  assign w_accept = (r_state == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (bus.in_valid) w_state_nxt = w_legal ? EXEC : DONE;
      EXEC: begin
        if (r_muldiv && (r_cnt != 4'd0)) begin
          w_state_nxt = WAIT;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      // The counter reaches zero on the edge that leaves WAIT.
      WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_func   <= 6'd0;
      r_op_0   <= 32'd0;
      r_op_1   <= 32'd0;
      r_result <= 32'd0;
      r_rd     <= 5'd0;
      r_err    <= 1'b0;
      r_muldiv <= 1'b0;
    end else begin
      if (w_accept) begin
        // Illegal instructions skip the ALU entirely, so nothing is driven.
        r_func   <= w_legal ? w_func : 6'd0;
        r_op_0   <= w_legal ? w_op_0 : 32'd0;
        r_op_1   <= w_legal ? w_op_1 : 32'd0;
        r_rd     <= w_legal ? w_rd : 5'd0;
        r_muldiv <= w_legal && w_muldiv;
        r_cnt    <= (w_legal && w_muldiv) ? LP_CNT_LOAD : 4'd0;
        r_result <= 32'd0;
        r_err    <= !w_legal;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_result <= bus.result;
        r_func   <= 6'd0;
        r_op_0   <= 32'd0;
        r_op_1   <= 32'd0;
      end
    end
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == DONE);
  assign bus.func       = r_func;
  assign bus.op_0       = r_op_0;
  assign bus.op_1       = r_op_1;
  assign bus.out_result = r_result;
  assign bus.out_rd     = r_rd;
  assign bus.out_err    = r_err;

endmodule
